// File: rtl/rom_fetch_seq_if.sv
// Request/response handshake bundle for rom_fetch_seq.
// The master modport is the requester/consumer, the slave modport is the fetch sequencer.
interface rom_fetch_seq_if #(
  parameter int ROM_ADDR = 11,
  parameter int ROM_BITS = 32
);
  logic                REQ_VALID;
  logic                REQ_READY;
  logic [ROM_ADDR-1:0] REQ_ADDR;
  logic [3:0]          REQ_LEN;
  logic                RSP_VALID;
  logic                RSP_READY;
  logic [ROM_BITS-1:0] RSP_DATA;
  logic                RSP_LAST;

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_LEN, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_LAST
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_LEN, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_LAST
  );
endinterface

// File: rtl/rom_fetch_seq.sv
// Burst ROM fetch sequencer: issues flow-controlled ROM reads and returns words through a small FIFO.
// Optional macro ROM_FETCH_SEQ_PARITY_EN adds an even-parity bit per word on RSP_PAR.
module rom_fetch_seq #(
  parameter int ROM_ADDR   = 11,
  parameter int ROM_BITS   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                FUNC_CLK_ROM_IN,
  input  logic                FUNC_RST_ROM_IN,
  rom_fetch_seq_if.slave      bus,
  output logic                FUNC_REN_ROM,
  output logic [ROM_ADDR-1:0] FUNC_ADDR_ROM_IN,
  input  logic [ROM_BITS-1:0] DATA_ROM_OUT,
`ifdef ROM_FETCH_SEQ_PARITY_EN
  output logic                RSP_PAR,
`endif
  output logic                BUSY
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef ROM_FETCH_SEQ_PARITY_EN
  localparam int ENTRY_W = ROM_BITS + 2;
`else
  localparam int ENTRY_W = ROM_BITS + 1;
`endif
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ROM_ADDR-1:0] addr_q;
  logic [4:0]          cnt_q;
  logic [RD_LAT-1:0]   pipe_v_q, pipe_l_q;
  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    occ_q;

  logic               rst, req_ready, accept, ren, can_issue;
  logic               push, pop, fifo_valid, head_last;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W:0]     outstanding;
  logic [ENTRY_W-1:0] push_entry, head;

  assign rst        = FUNC_RST_ROM_IN;
  assign req_ready  = (state_q == IDLE) & ~rst;
  assign accept     = bus.REQ_VALID & req_ready;
  assign fifo_valid = (occ_q != '0) & ~rst;
  assign pop        = fifo_valid & bus.RSP_READY;
  assign push       = pipe_v_q[RD_LAT-1] & ~rst;
  assign head       = mem[rd_ptr_q];
  assign head_last  = head[ROM_BITS];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + {{(CNT_W-1){1'b0}}, pipe_v_q[i]};
  end

  // Words already buffered plus reads still in the ROM pipe must fit in the FIFO.
  assign outstanding = {1'b0, occ_q} + {1'b0, inflight};
  assign can_issue   = outstanding < DEPTH_LIM;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: if (can_issue) begin
               ren = 1'b1;
               if (cnt_q == 5'd1) state_d = DRAIN;
             end
      DRAIN: if (pop && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) ren = 1'b0;
  end

  always_ff @(posedge FUNC_CLK_ROM_IN) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      pipe_v_q <= '0;
      pipe_l_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= bus.REQ_ADDR;
        cnt_q  <= {1'b0, bus.REQ_LEN} + 5'd1;
      end else if (ren) begin
        addr_q <= addr_q + 1'b1;
        cnt_q  <= cnt_q - 5'd1;
      end
      pipe_v_q[0] <= ren;
      pipe_l_q[0] <= ren & (cnt_q == 5'd1);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_l_q[i] <= pipe_l_q[i-1];
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

`ifdef ROM_FETCH_SEQ_PARITY_EN
  assign push_entry = {^DATA_ROM_OUT, pipe_l_q[RD_LAT-1], DATA_ROM_OUT};
  assign RSP_PAR    = fifo_valid & head[ROM_BITS+1];
`else
  assign push_entry = {pipe_l_q[RD_LAT-1], DATA_ROM_OUT};
`endif

  // NOTE: the storage array has no reset; the head is masked while empty, so stale contents never reach the outputs.
  always_ff @(posedge FUNC_CLK_ROM_IN) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  assign bus.REQ_READY = req_ready;
  assign bus.RSP_VALID = fifo_valid;
  assign bus.RSP_DATA  = fifo_valid ? head[ROM_BITS-1:0] : '0;
  assign bus.RSP_LAST  = fifo_valid & head_last;
  assign FUNC_REN_ROM     = ren;
  assign FUNC_ADDR_ROM_IN = rst ? '0 : addr_q;
  assign BUSY             = (state_q != IDLE) & ~rst;

endmodule

// File: tb/tb_rom_fetch_seq.sv
// Directed bench for rom_fetch_seq: table of bursts plus hand sequences for reset,
// backpressure/resume and held requests. Parity checks run when ROM_FETCH_SEQ_PARITY_EN is defined.
module tb_rom_fetch_seq;
  localparam int ROM_ADDR = 11;
  localparam int ROM_BITS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_fetch_seq_if #(.ROM_ADDR(ROM_ADDR), .ROM_BITS(ROM_BITS)) bus ();
  logic        ren;
  logic [10:0] rom_addr;
  logic [31:0] rom_q = '0;
  logic        busy;
`ifdef ROM_FETCH_SEQ_PARITY_EN
  logic        par;
`endif

  rom_fetch_seq #(.ROM_ADDR(ROM_ADDR), .ROM_BITS(ROM_BITS), .FIFO_DEPTH(4), .RD_LAT(1)) dut (
    .FUNC_CLK_ROM_IN (clk),
    .FUNC_RST_ROM_IN (rst),
    .bus             (bus),
    .FUNC_REN_ROM    (ren),
    .FUNC_ADDR_ROM_IN(rom_addr),
    .DATA_ROM_OUT    (rom_q),
`ifdef ROM_FETCH_SEQ_PARITY_EN
    .RSP_PAR         (par),
`endif
    .BUSY            (busy)
  );

  function automatic logic [31:0] rom_fn(input logic [10:0] a);
    if (a == 11'h200) return 32'h0000_0007;
    if (a == 11'h201) return 32'h0000_0003;
    return {5'h15, a, 5'h0A, a};
  endfunction

  // One-cycle ROM model
  always @(posedge clk) if (ren) rom_q <= rom_fn(rom_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: issued addresses, popped words, consecutive-read run length
  logic [10:0] iss_q[$];
  logic [31:0] rsp_d_q[$];
  logic        rsp_l_q[$];
  logic        rsp_p_q[$];
  bit          last_seen;
  int          last_pop_cyc, ren_run, ren_run_max;

  always @(negedge clk) begin
    if (!rst) begin
      if (ren) begin
        iss_q.push_back(rom_addr);
        ren_run = ren_run + 1;
        if (ren_run > ren_run_max) ren_run_max = ren_run;
      end else begin
        ren_run = 0;
      end
      if (bus.RSP_VALID && bus.RSP_READY) begin
        rsp_d_q.push_back(bus.RSP_DATA);
        rsp_l_q.push_back(bus.RSP_LAST);
`ifdef ROM_FETCH_SEQ_PARITY_EN
        rsp_p_q.push_back(par);
`endif
        if (bus.RSP_LAST) begin
          last_seen    = 1'b1;
          last_pop_cyc = cyc;
        end
      end
    end
  end

  task automatic clear_mon();
    iss_q.delete(); rsp_d_q.delete(); rsp_l_q.delete(); rsp_p_q.delete();
    last_seen = 1'b0; ren_run = 0; ren_run_max = 0; last_pop_cyc = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic do_req(input logic [10:0] a, input logic [3:0] l, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    bus.REQ_ADDR  = a;
    bus.REQ_LEN   = l;
    bus.REQ_VALID = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (bus.REQ_READY) begin ok = 1'b1; acc = cyc; end
      else begin @(posedge clk); #1; end
    end
    check("req_accept", ok, 1);
    @(posedge clk); #1;
    bus.REQ_VALID = 1'b0;
  endtask

  typedef struct {
    logic [10:0] addr;
    logic [3:0]  len;
    int          stall;
    int          exp_words;
    int          exp_stall_iss;
    logic [10:0] exp_last_addr;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int acc;
    logic [10:0] ea;
    @(posedge clk); #1;
    clear_mon();
    bus.RSP_READY = (v.stall == 0);
    do_req(v.addr, v.len, acc);
    if (v.stall > 0) begin
      repeat (v.stall) @(negedge clk);
      #1;
      check({tag, "_stall_issued"}, iss_q.size(), v.exp_stall_iss);
      check({tag, "_stall_ren"}, ren, 0);
      @(posedge clk); #1;
      bus.RSP_READY = 1'b1;
    end
    for (int i = 0; i < 400 && !last_seen; i++) begin @(negedge clk); #1; end
    check({tag, "_last_seen"}, last_seen, 1);
    @(negedge clk); #1;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_ready_after"}, bus.REQ_READY, 1);
    check({tag, "_words"}, rsp_d_q.size(), v.exp_words);
    check({tag, "_reads"}, iss_q.size(), v.exp_words);
    for (int i = 0; i < rsp_d_q.size(); i++) begin
      ea = v.addr + 11'(i);
      check($sformatf("%s_data%0d", tag, i), rsp_d_q[i], rom_fn(ea));
      check($sformatf("%s_last%0d", tag, i), rsp_l_q[i], (i == int'(v.len)));
    end
    for (int i = 0; i < iss_q.size(); i++) begin
      ea = v.addr + 11'(i);
      check($sformatf("%s_addr%0d", tag, i), iss_q[i], ea);
    end
    if (iss_q.size() > 0) check({tag, "_last_addr"}, iss_q[$], v.exp_last_addr);
    if (v.stall == 0) begin
      check({tag, "_latency"}, last_pop_cyc - acc, v.exp_lat);
      check({tag, "_ren_run"}, ren_run_max, v.exp_words);
    end
  endtask

  vec_t vecs[7];
  vec_t post_rst_vec;

  initial begin
    int  acc;
    bit  drop;
    logic [10:0] ea;

    vecs[0] = '{11'h010, 4'd0,  0,  1, 0, 11'h010,  3};
    vecs[1] = '{11'h7FE, 4'd3,  0,  4, 0, 11'h001,  6};
    vecs[2] = '{11'h000, 4'd15, 0, 16, 0, 11'h00F, 18};
    vecs[3] = '{11'h123, 4'd15, 20, 16, 4, 11'h132, 0};
    vecs[4] = '{11'h7FC, 4'd7,  10,  8, 4, 11'h003, 0};
    vecs[5] = '{11'h3FF, 4'd1,  0,  2, 0, 11'h400,  4};
    vecs[6] = '{11'h055, 4'd2,  8,  3, 3, 11'h057,  0};
    post_rst_vec = '{11'h100, 4'd1, 0, 2, 0, 11'h101, 4};

    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_LEN   = '0;
    bus.RSP_READY = 1'b1;
    clear_mon();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_req_ready", bus.REQ_READY, 0);
    check("rst_ren", ren, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_rsp_valid", bus.RSP_VALID, 0);
    check("rst_rsp_data", bus.RSP_DATA, 0);
    check("rst_rsp_last", bus.RSP_LAST, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_req_ready", bus.REQ_READY, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure stall, resume after one pop, and a request held while busy
    @(posedge clk); #1;
    clear_mon();
    bus.RSP_READY = 1'b0;
    do_req(11'h400, 4'd15, acc);
    bus.REQ_ADDR  = 11'h080;
    bus.REQ_LEN   = 4'd0;
    bus.REQ_VALID = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("bp_issued", iss_q.size(), 4);
    check("bp_req_ready", bus.REQ_READY, 0);
    check("bp_rsp_valid", bus.RSP_VALID, 1);
    check("bp_head_data", bus.RSP_DATA, rom_fn(11'h400));
    check("bp_head_last", bus.RSP_LAST, 0);
    @(negedge clk); #1;
    check("bp_head_stable", bus.RSP_DATA, rom_fn(11'h400));
    @(posedge clk); #1;
    bus.RSP_READY = 1'b1;
    @(negedge clk); #1;
    check("bp_ren_at_pop", ren, 0);
    @(posedge clk); #1;
    bus.RSP_READY = 1'b0;
    @(negedge clk); #1;
    check("bp_ren_resume", ren, 1);
    repeat (4) @(negedge clk);
    #1;
    check("bp_issued_after_pop", iss_q.size(), 5);
    @(posedge clk); #1;
    bus.RSP_READY = 1'b1;
    for (int i = 0; i < 300 && rsp_d_q.size() < 17; i++) begin
      @(negedge clk); #1;
      drop = bus.REQ_READY && bus.REQ_VALID;
      @(posedge clk); #1;
      if (drop) bus.REQ_VALID = 1'b0;
    end
    check("bp_valid_dropped", bus.REQ_VALID, 0);
    check("bp_words", rsp_d_q.size(), 17);
    check("bp_reads", iss_q.size(), 17);
    for (int i = 0; i < 16 && i < rsp_d_q.size(); i++) begin
      ea = 11'h400 + 11'(i);
      check($sformatf("bp_data%0d", i), rsp_d_q[i], rom_fn(ea));
      check($sformatf("bp_last%0d", i), rsp_l_q[i], (i == 15));
    end
    if (rsp_d_q.size() == 17) begin
      check("held_req_data", rsp_d_q[16], rom_fn(11'h080));
      check("held_req_last", rsp_l_q[16], 1);
    end
    for (int i = 0; i < 20 && busy; i++) begin @(negedge clk); #1; end
    check("bp_busy_end", busy, 0);

    // Reset in the middle of a 16-word burst
    @(posedge clk); #1;
    clear_mon();
    bus.RSP_READY = 1'b1;
    do_req(11'h000, 4'd15, acc);
    for (int i = 0; i < 100 && iss_q.size() < 5; i++) begin @(negedge clk); #1; end
    check("mid_issued", iss_q.size(), 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_rsp_valid", bus.RSP_VALID, 0);
    check("mid_rst_ren", ren, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", bus.REQ_READY, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    repeat (10) @(negedge clk);
    #1;
    check("mid_no_rsp", rsp_d_q.size(), 0);
    check("mid_no_reads", iss_q.size(), 0);
    check("mid_idle", busy, 0);
    run_vec(post_rst_vec, "post_rst");

`ifdef ROM_FETCH_SEQ_PARITY_EN
    @(posedge clk); #1;
    clear_mon();
    bus.RSP_READY = 1'b1;
    do_req(11'h200, 4'd1, acc);
    for (int i = 0; i < 100 && !last_seen; i++) begin @(negedge clk); #1; end
    check("par_words", rsp_p_q.size(), 2);
    if (rsp_p_q.size() == 2) begin
      check("par_7", rsp_p_q[0], 1);
      check("par_3", rsp_p_q[1], 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_fetch_seq.md
ROM_FETCH_SEQ -- requirements
Module: rom_fetch_seq

Interface
REQ-001 Parameter ROM_ADDR, 11: ROM address width.
REQ-002 Parameter ROM_BITS, 32: ROM data width.
REQ-003 Parameter FIFO_DEPTH, 4: response FIFO entries; power of two, at least 2.
REQ-004 Parameter RD_LAT, 1: ROM clock-to-data latency in cycles, range 1..2.
REQ-005 FUNC_CLK_ROM_IN  in  1  single clock; all logic is on its rising edge.
REQ-006 FUNC_RST_ROM_IN  in  1  reset; synchronous, active-high.
REQ-007 REQ_VALID  in  1  burst request valid.
REQ-008 REQ_READY  out  1  burst request accepted when REQ_VALID and REQ_READY are both high.
REQ-009 REQ_ADDR  in  ROM_ADDR  burst start address.
REQ-010 REQ_LEN  in  4  burst length minus 1, giving 1..16 words.
REQ-011 FUNC_REN_ROM  out  1  ROM read enable to the ROM DFX wrapper.
REQ-012 FUNC_ADDR_ROM_IN  out  ROM_ADDR  ROM read address to the ROM DFX wrapper.
REQ-013 DATA_ROM_OUT  in  ROM_BITS  ROM read data from the ROM DFX wrapper.
REQ-014 RSP_VALID  out  1  response word valid.
REQ-015 RSP_READY  in  1  consumer ready.
REQ-016 RSP_DATA  out  ROM_BITS  response word.
REQ-017 RSP_LAST  out  1  marks the final word of a burst.
REQ-018 BUSY  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-020 In IDLE, REQ_READY SHALL be 1; on an accepted request, the block SHALL load the address register with REQ_ADDR, load the remaining count with REQ_LEN+1, and move to ISSUE on the next cycle.
REQ-021 In ISSUE, the block SHALL assert FUNC_REN_ROM for exactly one cycle per word, and only when (FIFO occupancy + reads in flight) < FIFO_DEPTH.
REQ-022 Each issued read SHALL drive FUNC_ADDR_ROM_IN with the current address, then increment the address modulo 2^ROM_ADDR, so 2047 wraps to 0, and decrement the remaining count.
REQ-023 When the read that takes the remaining count to zero is issued, the FSM SHALL move to DRAIN.
REQ-024 An RD_LAT-deep shift pipe SHALL carry a valid bit and a last tag for each issued read.
REQ-025 When a pipe entry exits, the block SHALL write DATA_ROM_OUT and the last tag into the FIFO in that same cycle; FIFO overflow is impossible by REQ-021.
REQ-026 The FIFO head SHALL drive RSP_DATA and RSP_LAST directly (no output register); RSP_VALID SHALL equal FIFO not-empty; a pop occurs on RSP_VALID and RSP_READY.
REQ-027 A FIFO push and pop in the same cycle SHALL leave occupancy unchanged, including when the FIFO is full or empty; pushing into an empty FIFO SHALL make RSP_VALID high on the next cycle.
REQ-028 In DRAIN, when the word tagged last is popped, the FSM SHALL return to IDLE on the next cycle.
REQ-029 REQ_READY SHALL be 0 in ISSUE and DRAIN; a REQ_VALID held high there SHALL be ignored and SHALL NOT be lost.
REQ-030 With RSP_READY held at 1 and RD_LAT=1, a 16-word burst SHALL complete (last word popped) in 18 cycles after acceptance.
REQ-031 While RSP_READY is 0, FUNC_REN_ROM SHALL stall after FIFO_DEPTH words are outstanding; issue SHALL resume in the cycle after a pop.
REQ-032 RSP_DATA and RSP_LAST SHALL stay stable while RSP_VALID is high and RSP_READY is low.

Reset
REQ-033 While FUNC_RST_ROM_IN is sampled high, the following SHALL hold: state IDLE, FIFO empty, pipe cleared, counters 0, REQ_READY=0, FUNC_REN_ROM=0, FUNC_ADDR_ROM_IN=0, RSP_VALID=0, RSP_DATA=0, RSP_LAST=0, BUSY=0.
REQ-034 REQ_READY SHALL rise to 1 in the first cycle after reset deasserts.
REQ-035 Reset asserted mid-burst SHALL abort the burst; in-flight ROM data SHALL be discarded and no RSP_VALID SHALL appear for it.

Configuration
REQ-036 With macro ROM_FETCH_SEQ_PARITY_EN defined, the FIFO SHALL be one bit wider and output port RSP_PAR (out, 1) SHALL carry the even parity of RSP_DATA, computed at FIFO write and reset to 0.
REQ-037 Without ROM_FETCH_SEQ_PARITY_EN, port RSP_PAR and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 Single word: REQ_ADDR=0x010, REQ_LEN=0, RSP_READY=1 -> one FUNC_REN_ROM pulse at 0x010; one response word equal to ROM[0x010] with RSP_LAST=1; FSM back in IDLE.
REQ-039 Wrap: REQ_ADDR=0x7FE, REQ_LEN=3 -> reads at 0x7FE, 0x7FF, 0x000, 0x001 in order; RSP_LAST on the 4th word only.
REQ-040 Backpressure: REQ_LEN=15 with RSP_READY=0 -> exactly 4 reads issued and then a stall; releasing RSP_READY delivers all 16 words in order with none dropped or duplicated.
REQ-041 Throughput: REQ_LEN=15 with RSP_READY=1 -> 16 consecutive FUNC_REN_ROM cycles; the last word is popped 18 cycles after acceptance.
REQ-042 Reset mid-burst: assert FUNC_RST_ROM_IN after 5 of 16 words -> no RSP_VALID afterwards; a new request with REQ_ADDR=0x100, REQ_LEN=1 then returns exactly 2 words.
REQ-043 Parity (macro defined): a ROM word of 0x0000_0007 -> RSP_PAR=1; a ROM word of 0x0000_0003 -> RSP_PAR=0.
